// File: rtl/imem_loader.sv
// imem_loader: writable 64-word instruction memory for the LEGv8 core.
// A program arrives as a byte stream (header = word count C, then C words
// sent MSB first). Words past the image are zero-filled, and the core is held
// in reset until a complete image has been written.
module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    output logic [N-1:0]               q,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       error,
    output logic [$clog2(DEPTH):0]     words_loaded
);

    localparam int AW    = $clog2(DEPTH);
    localparam int BYTES = N / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_FILL, S_DONE, S_ERR
    } state_t;

    state_t          r_state, w_next;
    logic [N-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_waddr;
    logic [BW-1:0]   r_bidx;
    logic [N-9:0]    r_buf;      // bytes of the current word received so far
    logic [AW:0]     r_count;    // C from the header
    logic [AW:0]     r_words;

    logic            w_xfer;
    logic            w_word_end;
    logic            w_last_word;
    logic            w_hdr_ok;
    logic            w_waddr_top;
    logic            w_we;
    logic [N-1:0]    w_wdata;

    assign w_xfer      = rx_valid & rx_ready;
    assign w_word_end  = (r_bidx == BW'(BYTES - 1));
    assign w_last_word = (r_words == r_count - (AW+1)'(1));
    assign w_hdr_ok    = (rx_data != 8'd0) && (rx_data <= 8'(DEPTH));
    assign w_waddr_top = (r_waddr == AW'(DEPTH - 1));

    assign q            = r_mem[addr];
    assign words_loaded = r_words;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state, handshake/status decode and RAM write request
    always_comb begin
        w_next   = r_state;
        w_we     = 1'b0;
        w_wdata  = '0;
        rx_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_HDR;
            S_HDR: begin
                rx_ready = 1'b1;
                if (w_xfer) w_next = w_hdr_ok ? S_DATA : S_ERR;
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (w_xfer && w_word_end) begin
                    w_we    = 1'b1;
                    w_wdata = {r_buf, rx_data};
                    if (w_last_word)
                        w_next = (r_count == (AW+1)'(DEPTH)) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                w_we = 1'b1;
                if (w_waddr_top) w_next = S_DONE;
            end
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) w_next = S_HDR;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) w_next = S_HDR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Byte assembly, write address and word counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_waddr <= '0;
            r_bidx  <= '0;
            r_buf   <= '0;
            r_count <= '0;
            r_words <= '0;
        end else begin
            // A fresh valid header restarts the image at address 0
            if (r_state == S_HDR && w_xfer && w_hdr_ok) begin
                r_count <= rx_data[AW:0];
                r_words <= '0;
                r_waddr <= '0;
                r_bidx  <= '0;
            end
            if (r_state == S_DATA && w_xfer) begin
                r_buf <= {r_buf[N-17:0], rx_data};
                if (w_word_end) begin
                    r_bidx  <= '0;
                    r_words <= r_words + (AW+1)'(1);
                end else begin
                    r_bidx <= r_bidx + BW'(1);
                end
            end
            // Saturate at the last word so the address never wraps within a load
            if (w_we && !w_waddr_top) r_waddr <= r_waddr + AW'(1);
        end
    end

    // Instruction RAM; contents survive reset, writes are suppressed during it
    always_ff @(posedge clk) begin
        if (reset && w_we) r_mem[r_waddr] <= w_wdata;
    end

endmodule
